stopwatch_key_ctrl: RTL
=======================

// Module: stopwatch_key_ctrl
// PURPOSE
//   Conditions the raw stopwatch push-button before it reaches the timing core.
//   2-FF synchroniser, press/release debounce, short/long press classification.
//   Short press toggles the run level (gates the base divider clock); long press
//   emits a one-cycle clear pulse and stops the watch. All outputs are synchronous to clk.
// PARAMETERS
//   DEB_CYCLES   240000    consecutive stable cycles to accept a press or release (20 ms @ 12 MHz); >=2
//   LONG_CYCLES  12000000  cycles held after debounced press to declare long press (1 s @ 12 MHz); >DEB_CYCLES
//   CNT_W        24        width of deb_cnt and hold_cnt; must hold LONG_CYCLES
// PORTS
//   clk          in   1  system clock, 12 MHz
//   rst          in   1  reset, asynchronous, active-low
//   key_raw      in   1  raw button, active-high, bouncing, asynchronous
//   key_level    out  1  debounced button level (1 = pressed)
//   run          out  1  stopwatch run enable (1 = counting)
//   toggle_pulse out  1  one-cycle strobe when run toggles
//   clear_pulse  out  1  one-cycle strobe requesting counter clear
// BEHAVIOUR
//   Reset (rst=0, any time, mid-press included): state=IDLE, sync regs=0,
//     deb_cnt=0, hold_cnt=0, long_flag=0, key_level=0, run=0, both pulses 0.
//   key_s = key_raw after two flops (2-cycle latency); the FSM sees only key_s.
//   FSM (registered, one transition per cycle):
//   IDLE: deb_cnt=0, hold_cnt=0, long_flag=0; key_s=1 -> DEB_PRESS.
//   DEB_PRESS: key_s=0 -> IDLE (glitch rejected, nothing emitted);
//     else deb_cnt++; at deb_cnt==DEB_CYCLES-1 -> HELD, key_level<=1, deb_cnt<=0.
//   HELD: key_s=0 -> DEB_REL, deb_cnt<=0; else hold_cnt++;
//     at hold_cnt==LONG_CYCLES-1 -> LONG: clear_pulse=1 one cycle, run<=0, long_flag<=1.
//   LONG: hold_cnt frozen; key_s=0 -> DEB_REL, deb_cnt<=0.
//   DEB_REL: key_s=1 -> back to HELD (long_flag=0) or LONG (long_flag=1),
//     hold_cnt not advanced while in DEB_REL, no output change;
//     else deb_cnt++; at deb_cnt==DEB_CYCLES-1 -> IDLE, key_level<=0;
//     if long_flag=0: run<=~run, toggle_pulse=1 for that one cycle.
//   Short press acts on release; long press acts once while still held, and its
//     release produces no toggle. toggle_pulse and clear_pulse never both 1.
//   Counters never wrap: deb_cnt cleared on each state entry, hold_cnt stops at LONG.
//   key_level changes only on completed debounce; pulses exactly 1 cycle wide.
// TESTING (bench parameters DEB_CYCLES=4, LONG_CYCLES=20)
//   Reset: rst low with key_raw=1 -> all outputs 0; release rst, key held ->
//     key_level=1 after 2+4 cycles, run stays 0.
//   Glitch: key_raw high 3 cycles then low -> key_level, run, pulses remain 0.
//   Short press: key_raw high 10 cycles, low -> single toggle_pulse about 6 cycles
//     after fall, run 0->1; repeat -> run 1->0.
//   Long press from run=1: key_raw high 40 cycles -> one clear_pulse ~26 cycles after
//     rise, run=0; release -> no toggle_pulse, key_level returns 0.
//   Release bounce: during release toggle key_raw 1-0-1-0 with 2-cycle gaps, then low ->
//     exactly one toggle_pulse, no clear_pulse.
//   Mid-operation reset: assert rst in HELD with run=1 -> run=0 immediately; after
//     deassert with key low, next short press gives run=1.

Source files
------------

// File: rtl/stopwatch_key_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | stopwatch_key_ctrl: push-button synchroniser, debouncer, short/long press   |
// | classifier driving the stopwatch run level and clear request.               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module stopwatch_key_ctrl #(
  parameter int DEB_CYCLES  = 240000,
  parameter int LONG_CYCLES = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic run,
  output logic toggle_pulse,
  output logic clear_pulse
);

  localparam logic [CNT_W-1:0] c_DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEB_PRESS = 3'd1,
    S_HELD      = 3'd2,
    S_LONG      = 3'd3,
    S_DEB_REL   = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_long_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_deb_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_long_flag  <= 1'b0;
      key_level    <= 1'b0;
      run          <= 1'b0;
      toggle_pulse <= 1'b0;
      clear_pulse  <= 1'b0;
    end else begin
      toggle_pulse <= 1'b0;
      clear_pulse  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_deb_cnt   <= '0;
          r_hold_cnt  <= '0;
          r_long_flag <= 1'b0;
          if (r_sync2) r_state <= S_DEB_PRESS;
        end
        S_DEB_PRESS: begin
          if (!r_sync2) begin
            r_state   <= S_IDLE;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == c_DEB_LAST) begin
            r_state   <= S_HELD;
            key_level <= 1'b1;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!r_sync2) begin
            r_state   <= S_DEB_REL;
            r_deb_cnt <= '0;
          end else if (r_hold_cnt == c_LONG_LAST) begin
            r_state     <= S_LONG;
            clear_pulse <= 1'b1;
            run         <= 1'b0;
            r_long_flag <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_LONG: begin
          // hold_cnt stays frozen here so it can never wrap
          if (!r_sync2) begin
            r_state   <= S_DEB_REL;
            r_deb_cnt <= '0;
          end
        end
        S_DEB_REL: begin
          if (r_sync2) begin
            r_state   <= r_long_flag ? S_LONG : S_HELD;
            r_deb_cnt <= '0;
          end else if (r_deb_cnt == c_DEB_LAST) begin
            r_state   <= S_IDLE;
            key_level <= 1'b0;
            r_deb_cnt <= '0;
            // a long press already acted while held; its release is silent
            if (!r_long_flag) begin
              run          <= ~run;
              toggle_pulse <= 1'b1;
            end
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
